// File: rtl/wb_initiator_pkg.sv
// Shared types for wb_initiator: FSM state encoding and response status codes.
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STROBE = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  localparam logic [1:0] ST_OK  = 2'b00;
  localparam logic [1:0] ST_ERR = 2'b01;
  localparam logic [1:0] ST_RTY = 2'b10;
  localparam logic [1:0] ST_TMO = 2'b11;

  // Resolve simultaneous terminations: err > rty > ack.
  function automatic logic [1:0] term_status(input logic err, input logic rty);
    if (err) return ST_ERR;
    if (rty) return ST_RTY;
    return ST_OK;
  endfunction

endpackage

// File: rtl/wb_initiator_timeout.sv
// Saturating cycle counter that flags the TIMEOUT-th active cycle of a bus transaction.
module wb_initiator_timeout #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic count_en_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (count_en_i && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // cnt_q counts completed active cycles, so the current one is number cnt_q+1.
  assign expired_o = count_en_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_initiator.sv
// Single-outstanding Wishbone B4 pipelined master with a valid/ready request/response front end.
// Define WB_INITIATOR_TIMEOUT_EN to abort transactions after TIMEOUT cycles with status TMO.
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_adr_i,
  input  logic [3:0]        req_sel_i,
  input  logic [31:0]       req_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_dat_o,
  output logic [1:0]        rsp_status_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [ADDR_W-1:0] wb_adr_o,
  output logic [3:0]        wb_sel_o,
  output logic [31:0]       wb_dat_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic              wb_rty_i,
  input  logic              wb_stall_i,
  input  logic [31:0]       wb_dat_i
);

  state_e            state_q;
  logic              req_ready_q, rsp_valid_q;
  logic [31:0]       rsp_dat_q;
  logic [1:0]        rsp_status_q;
  logic              cyc_q, stb_q, we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [3:0]        sel_q;
  logic [31:0]       dat_q;

  logic accept, active, term_hit, timeout_hit;

  assign accept   = (state_q == S_IDLE) && req_valid_i && req_ready_q;
  assign active   = (state_q == S_STROBE) || (state_q == S_WAIT);
  // A stalled strobe has not been taken by the slave, so terminations then are not ours.
  assign term_hit = ((state_q == S_WAIT) || ((state_q == S_STROBE) && !wb_stall_i)) &&
                    (wb_ack_i || wb_err_i || wb_rty_i);

`ifdef WB_INITIATOR_TIMEOUT_EN
  wb_initiator_timeout #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (accept),
    .count_en_i (active),
    .expired_o  (timeout_hit)
  );
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT == 0);
  assign timeout_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      sel_q        <= '0;
      dat_q        <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            req_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            stb_q       <= 1'b1;
            we_q        <= req_we_i;
            adr_q       <= req_adr_i;
            sel_q       <= req_sel_i;
            dat_q       <= req_we_i ? req_dat_i : '0;
            state_q     <= S_STROBE;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        S_STROBE, S_WAIT: begin
          if (term_hit || timeout_hit) begin
            cyc_q        <= 1'b0;
            stb_q        <= 1'b0;
            we_q         <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= term_hit ? term_status(wb_err_i, wb_rty_i) : ST_TMO;
            rsp_dat_q    <= (term_hit && wb_ack_i && !wb_err_i && !wb_rty_i && !we_q)
                            ? wb_dat_i : '0;
            state_q      <= S_RESP;
          end else if ((state_q == S_STROBE) && !wb_stall_i) begin
            stb_q   <= 1'b0;
            state_q <= S_WAIT;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = stb_q;
  assign wb_we_o      = we_q;
  assign wb_adr_o     = adr_q;
  assign wb_sel_o     = sel_q;
  assign wb_dat_o     = dat_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Directed self-checking bench for wb_initiator; inputs driven and outputs sampled on the falling edge.
module tb_wb_initiator;

  logic        clk, rst_n;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_adr;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_status;
  logic        cyc, stb, we;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_o;
  logic        ack, err, rty, stall;
  logic [31:0] dat_i;

  int n_tests = 0;
  int n_fail  = 0;

  wb_initiator #(
    .ADDR_W  (32),
    .TIMEOUT (8)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_we_i     (req_we),
    .req_adr_i    (req_adr),
    .req_sel_i    (req_sel),
    .req_dat_i    (req_dat),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_dat_o    (rsp_dat),
    .rsp_status_o (rsp_status),
    .wb_cyc_o     (cyc),
    .wb_stb_o     (stb),
    .wb_we_o      (we),
    .wb_adr_o     (adr),
    .wb_sel_o     (sel),
    .wb_dat_o     (dat_o),
    .wb_ack_i     (ack),
    .wb_err_i     (err),
    .wb_rty_i     (rty),
    .wb_stall_i   (stall),
    .wb_dat_i     (dat_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Waits (bounded) for req_ready, presents one request for cycle N, returns at the N+1 falling edge.
  task automatic start_req(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    int unsigned waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL req_ready_wait: got %b want 1 within 20 cycles", req_ready);
    end
    req_valid = 1'b1; req_we = w; req_adr = a; req_sel = s; req_dat = d;
    @(negedge clk);
    req_valid = 1'b0; req_dat = 32'hDEAD_BEEF;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_tests++;
    if ({cyc, stb, we, adr, sel, dat_o, rsp_valid, rsp_dat, rsp_status, req_ready} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got cyc%b stb%b we%b adr%h sel%h dat%h rv%b rd%h st%b rdy%b want all 0",
               cyc, stb, we, adr, sel, dat_o, rsp_valid, rsp_dat, rsp_status, req_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_read();
    start_req(1'b0, 32'h0000_0004, 4'hF, 32'h5555_AAAA);
    n_tests++;
    if ({cyc, stb, we, req_ready, rsp_valid} !== 5'b11000 || adr !== 32'h4 || sel !== 4'hF || dat_o !== 32'h0) begin
      n_fail++;
      $display("FAIL read_strobe: got cyc%b stb%b we%b rdy%b rv%b adr%h sel%h dat%h want 1 1 0 0 0 00000004 f 00000000",
               cyc, stb, we, req_ready, rsp_valid, adr, sel, dat_o);
    end
    ack = 1'b1; dat_i = 32'hCAFE_0001;
    @(negedge clk);
    ack = 1'b0; dat_i = 32'h0BAD_0BAD;
    n_tests++;
    if ({rsp_valid, cyc, stb, req_ready} !== 4'b1000 || rsp_dat !== 32'hCAFE_0001 || rsp_status !== 2'b00) begin
      n_fail++;
      $display("FAIL read_rsp: got rv%b cyc%b stb%b rdy%b dat%h st%b want 1 0 0 0 cafe0001 00",
               rsp_valid, cyc, stb, req_ready, rsp_dat, rsp_status);
    end
    consume();
    n_tests++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      n_fail++; $display("FAIL read_idle: got rv%b rdy%b want 0 1", rsp_valid, req_ready);
    end
  endtask

  task automatic test_write_stall();
    stall = 1'b1;
    start_req(1'b1, 32'h0000_0010, 4'hF, 32'h1234_5678);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({cyc, stb, we} !== 3'b111 || adr !== 32'h10 || sel !== 4'hF || dat_o !== 32'h1234_5678) begin
        n_fail++;
        $display("FAIL write_stall_hold[%0d]: got cyc%b stb%b we%b adr%h sel%h dat%h want 1 1 1 00000010 f 12345678",
                 i, cyc, stb, we, adr, sel, dat_o);
      end
      ack = (i == 1);
      if (i == 3) stall = 1'b0;
      @(negedge clk);
    end
    n_tests++;
    if ({cyc, stb, we, rsp_valid} !== 4'b1010) begin
      n_fail++; $display("FAIL write_wait: got cyc%b stb%b we%b rv%b want 1 0 1 0", cyc, stb, we, rsp_valid);
    end
    ack = 1'b1; dat_i = 32'hFFFF_FFFF;
    @(negedge clk);
    ack = 1'b0;
    n_tests++;
    if ({rsp_valid, cyc, we} !== 3'b100 || rsp_dat !== 32'h0 || rsp_status !== 2'b00) begin
      n_fail++;
      $display("FAIL write_rsp: got rv%b cyc%b we%b dat%h st%b want 1 0 0 00000000 00", rsp_valid, cyc, we, rsp_dat, rsp_status);
    end
    consume();
  endtask

  task automatic test_err_rty();
    start_req(1'b0, 32'h0000_0020, 4'h3, 32'h0);
    err = 1'b1; ack = 1'b1; dat_i = 32'h7777_7777;
    @(negedge clk);
    err = 1'b0; ack = 1'b0;
    n_tests++;
    if ({rsp_valid, cyc} !== 2'b10 || rsp_status !== 2'b01 || rsp_dat !== 32'h0) begin
      n_fail++; $display("FAIL err_prio: got rv%b cyc%b st%b dat%h want 1 0 01 00000000", rsp_valid, cyc, rsp_status, rsp_dat);
    end
    consume();
    start_req(1'b0, 32'h0000_0024, 4'hC, 32'h0);
    @(negedge clk);
    n_tests++;
    if ({cyc, stb, rsp_valid} !== 3'b100) begin
      n_fail++; $display("FAIL rty_wait: got cyc%b stb%b rv%b want 1 0 0", cyc, stb, rsp_valid);
    end
    rty = 1'b1;
    @(negedge clk);
    rty = 1'b0;
    n_tests++;
    if ({rsp_valid, cyc} !== 2'b10 || rsp_status !== 2'b10 || rsp_dat !== 32'h0) begin
      n_fail++; $display("FAIL rty_rsp: got rv%b cyc%b st%b dat%h want 1 0 10 00000000", rsp_valid, cyc, rsp_status, rsp_dat);
    end
    consume();
  endtask

  task automatic test_backpressure();
    start_req(1'b0, 32'h0000_0030, 4'hF, 32'h0);
    ack = 1'b1; dat_i = 32'hA5A5_5A5A;
    @(negedge clk);
    ack = 1'b0; dat_i = 32'h0;
    req_valid = 1'b1; req_we = 1'b0; req_adr = 32'h0000_0040; req_sel = 4'h1;
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if ({rsp_valid, req_ready, cyc} !== 3'b100 || rsp_dat !== 32'hA5A5_5A5A || rsp_status !== 2'b00) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: got rv%b rdy%b cyc%b dat%h st%b want 1 0 0 a5a55a5a 00",
                 i, rsp_valid, req_ready, cyc, rsp_dat, rsp_status);
      end
      if (i == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    rsp_ready = 1'b0;
    n_tests++;
    if ({rsp_valid, req_ready, cyc} !== 3'b010) begin
      n_fail++; $display("FAIL bp_idle: got rv%b rdy%b cyc%b want 0 1 0", rsp_valid, req_ready, cyc);
    end
    @(negedge clk);
    req_valid = 1'b0;
    n_tests++;
    if ({cyc, stb} !== 2'b11 || adr !== 32'h40 || sel !== 4'h1) begin
      n_fail++; $display("FAIL bp_next_req: got cyc%b stb%b adr%h sel%h want 1 1 00000040 1", cyc, stb, adr, sel);
    end
    ack = 1'b1; dat_i = 32'h0000_0042;
    @(negedge clk);
    ack = 1'b0;
    consume();
  endtask

  task automatic test_timeout();
    start_req(1'b0, 32'h0000_0050, 4'hF, 32'h0);
`ifdef WB_INITIATOR_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if ({cyc, rsp_valid} !== 2'b10) begin
        n_fail++; $display("FAIL tmo_active[%0d]: got cyc%b rv%b want 1 0", i, cyc, rsp_valid);
      end
      @(negedge clk);
    end
    n_tests++;
    if ({cyc, stb, rsp_valid} !== 3'b001 || rsp_status !== 2'b11 || rsp_dat !== 32'h0) begin
      n_fail++;
      $display("FAIL tmo_rsp: got cyc%b stb%b rv%b st%b dat%h want 0 0 1 11 00000000", cyc, stb, rsp_valid, rsp_status, rsp_dat);
    end
    consume();
`else
    for (int i = 0; i < 100; i++) begin
      n_tests++;
      if ({cyc, rsp_valid} !== 2'b10) begin
        n_fail++; $display("FAIL no_tmo_wait[%0d]: got cyc%b rv%b want 1 0", i, cyc, rsp_valid);
      end
      @(negedge clk);
    end
    ack = 1'b1; dat_i = 32'h0000_0099;
    @(negedge clk);
    ack = 1'b0;
    n_tests++;
    if ({cyc, rsp_valid} !== 2'b01 || rsp_status !== 2'b00 || rsp_dat !== 32'h99) begin
      n_fail++; $display("FAIL no_tmo_rsp: got cyc%b rv%b st%b dat%h want 0 1 00 00000099", cyc, rsp_valid, rsp_status, rsp_dat);
    end
    consume();
`endif
  endtask

  task automatic test_reset_mid();
    start_req(1'b1, 32'h0000_0060, 4'hF, 32'h1111_2222);
    @(negedge clk);
    n_tests++;
    if ({cyc, stb, we} !== 3'b101) begin
      n_fail++; $display("FAIL rstmid_wait: got cyc%b stb%b we%b want 1 0 1", cyc, stb, we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({cyc, stb, we, rsp_valid, req_ready} !== 5'b00000 || adr !== 32'h0) begin
      n_fail++; $display("FAIL rstmid_async: got cyc%b stb%b we%b rv%b rdy%b adr%h want 0 0 0 0 0 00000000",
                         cyc, stb, we, rsp_valid, req_ready, adr);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req_ready, rsp_valid, cyc} !== 3'b100) begin
      n_fail++; $display("FAIL rstmid_release: got rdy%b rv%b cyc%b want 1 0 0", req_ready, rsp_valid, cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_adr = '0; req_sel = '0; req_dat = '0;
    rsp_ready = 1'b0; ack = 1'b0; err = 1'b0; rty = 1'b0; stall = 1'b0; dat_i = '0;
    test_reset();
    test_read();
    test_write_stall();
    test_err_rty();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
